// File: rtl/mxn_pipe_arbiter_pkg.sv
// Shared types, tag encodings and the round-robin pick function for the
// two-port pipelined arbiter.
package mxn_pipe_arbiter_pkg;

  // Source tag carried alongside every word in the pipeline.
  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_e;

  localparam port_e TAG_P0   = PORT_0;
  localparam port_e TAG_P1   = PORT_1;
  // Reset value of the "last granted" flag; port 0 wins the first contention.
  localparam port_e LAST_RST = PORT_1;

  localparam int DEFAULT_M = 3;
  localparam int DEFAULT_N = 4;

  // One-hot grant for two requesters; on contention the port not granted last wins.
  function automatic logic [1:0] rrPick(input logic [1:0] req, input port_e last);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (last == PORT_1) ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mxn_pipe_arbiter_if.sv
// Handshake bundle between the two requesters, the two consumers and the
// shared pipeline. The design side uses 'slave'; producers/consumers use 'master'.
interface mxn_pipe_arbiter_if #(
  parameter int M = 3
);
  logic         in0_valid;
  logic [M-1:0] in0_data;
  logic         in0_ready;
  logic         in1_valid;
  logic [M-1:0] in1_data;
  logic         in1_ready;
  logic         out0_valid;
  logic [M-1:0] out0_data;
  logic         out0_ready;
  logic         out1_valid;
  logic [M-1:0] out1_data;
  logic         out1_ready;
  logic         busy;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out0_ready, out1_ready,
    output in0_ready, in1_ready, out0_valid, out0_data, out1_valid, out1_data, busy
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out0_ready, out1_ready,
    input  in0_ready, in1_ready, out0_valid, out0_data, out1_valid, out1_data, busy
  );
endinterface

// File: rtl/mxn_pipe_arbiter_rr_arb2.sv
// Two-request round-robin arbiter. Grants are only issued while 'en' is high,
// and the remembered last winner changes only when a grant is actually issued.
module mxn_rr_arb2
  import mxn_pipe_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  port_e last_q;
  port_e last_d;

  // Grant decode and next value of the last-winner flag.
  always_comb begin
    gnt    = en ? rrPick(req, last_q) : 2'b00;
    last_d = last_q;
    if (gnt[1]) begin
      last_d = PORT_1;
    end else if (gnt[0]) begin
      last_d = PORT_0;
    end
  end

  // Last-winner register; reset makes port 0 the next contention winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mxn_pipe_arbiter.sv
// Shares one N-deep, M-bit pipeline between two requesters. Each admitted word
// carries a source tag; the head word is steered to the consumer matching it.
// The whole pipeline advances together whenever the head can leave (or is empty).
module mxn_pipe_arbiter
  import mxn_pipe_arbiter_pkg::*;
#(
  parameter int M = DEFAULT_M,
  parameter int N = DEFAULT_N
) (
  input logic               clk,
  input logic               rst,
  mxn_pipe_arbiter_if.slave bus
);

  logic [N-1:0]        vld_q, vld_d;
  logic [N-1:0]        tag_q, tag_d;
  logic [N-1:0][M-1:0] dat_q, dat_d;

  logic       headOk;
  logic       adv;
  logic [1:0] gnt;

  // Index 0 is the entry stage, index N-1 is the head.
  assign headOk = !vld_q[N-1] |
                  ((tag_q[N-1] == TAG_P0) ? bus.out0_ready : bus.out1_ready);
  assign adv    = headOk;

  mxn_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.in1_valid, bus.in0_valid}),
    .en  (adv),
    .gnt (gnt)
  );

  assign bus.in0_ready = gnt[0];
  assign bus.in1_ready = gnt[1];

  // Global shift: on advance every stage takes its predecessor, and the entry
  // stage takes the granted word or a zeroed bubble when nobody was granted.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    dat_d = dat_q;
    if (adv) begin
      for (int k = N - 1; k > 0; k--) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
      vld_d[0] = |gnt;
      tag_d[0] = gnt[1] ? TAG_P1 : TAG_P0;
      if (gnt[1]) begin
        dat_d[0] = bus.in1_data;
      end else if (gnt[0]) begin
        dat_d[0] = bus.in0_data;
      end else begin
        dat_d[0] = '0;
      end
    end
  end

  // Pipeline registers; reset discards all in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
    end
  end

  assign bus.out0_valid = vld_q[N-1] & (tag_q[N-1] == TAG_P0);
  assign bus.out1_valid = vld_q[N-1] & (tag_q[N-1] == TAG_P1);
  assign bus.out0_data  = dat_q[N-1];
  assign bus.out1_data  = dat_q[N-1];
  assign bus.busy       = |vld_q;

endmodule

// File: tb/tb_mxn_pipe_arbiter.sv
// Randomised plus directed bench for mxn_pipe_arbiter (M=3, N=4). A queue-based
// reference model predicts readies and head contents every cycle; accepted words
// go into a scoreboard that a separate monitor drains on each output handshake.
module tb_mxn_pipe_arbiter;

  localparam int M = 3;
  localparam int N = 4;

  typedef struct {
    logic         v;
    logic         t;
    logic [M-1:0] d;
    logic         known;
  } slot_t;

  typedef struct {
    logic         t;
    logic [M-1:0] d;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mxn_pipe_arbiter_if #(.M(M)) bus ();

  mxn_pipe_arbiter #(.M(M), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  slot_t pipeQ[$];
  word_t expQ[$];
  int    lastPort   = 1;
  int    predGrant  = -1;
  logic  predAdv    = 1'b0;
  logic  modelValid = 1'b0;

  logic         drvV0, drvV1, drvR0, drvR1;
  logic [M-1:0] drvD0, drvD1;

  // Single comparison with counting and a FAIL line on disagreement.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference prediction of this cycle's readies and head-facing outputs.
  task automatic checkOutput();
    slot_t h;
    logic  expBusy;
    h = pipeQ[0];
    predAdv = !h.v || (h.t ? drvR1 : drvR0);
    if (!predAdv)             predGrant = -1;
    else if (drvV0 && drvV1)  predGrant = (lastPort == 1) ? 0 : 1;
    else if (drvV0)           predGrant = 0;
    else if (drvV1)           predGrant = 1;
    else                      predGrant = -1;
    expBusy = 1'b0;
    foreach (pipeQ[i]) expBusy |= pipeQ[i].v;
    checkVal("in0_ready",  32'(bus.in0_ready),  32'(predGrant == 0));
    checkVal("in1_ready",  32'(bus.in1_ready),  32'(predGrant == 1));
    checkVal("out0_valid", 32'(bus.out0_valid), 32'(h.v && !h.t));
    checkVal("out1_valid", 32'(bus.out1_valid), 32'(h.v && h.t));
    checkVal("busy",       32'(bus.busy),       32'(expBusy));
    if (h.v || h.known) begin
      checkVal("out0_data", 32'(bus.out0_data), 32'(h.d));
      checkVal("out1_data", 32'(bus.out1_data), 32'(h.d));
    end
  endtask

  // Advance the reference model by one clock edge.
  task automatic updateModel(input logic rstV);
    slot_t s;
    word_t w;
    if (rstV) begin
      pipeQ.delete();
      for (int i = 0; i < N; i++) begin
        s = '{v: 1'b0, t: 1'b0, d: '0, known: 1'b1};
        pipeQ.push_back(s);
      end
      expQ.delete();
      lastPort   = 1;
      modelValid = 1'b1;
    end else if (modelValid && predAdv) begin
      void'(pipeQ.pop_front());
      if (predGrant >= 0) begin
        s = '{v: 1'b1, t: (predGrant == 1), d: (predGrant == 1) ? drvD1 : drvD0, known: 1'b1};
        w = '{t: s.t, d: s.d};
        expQ.push_back(w);
        lastPort = predGrant;
      end else begin
        s = '{v: 1'b0, t: 1'b0, d: '0, known: 1'b0};
      end
      pipeQ.push_back(s);
    end
  endtask

  // Drive one cycle of inputs, check the pre-edge outputs, then step the model.
  task automatic applyStimulus(input logic rstV, input logic v0, input int d0,
                               input logic v1, input int d1,
                               input logic r0, input logic r1);
    @(negedge clk);
    rst   = rstV;
    drvV0 = v0; drvD0 = d0[M-1:0];
    drvV1 = v1; drvD1 = d1[M-1:0];
    drvR0 = r0; drvR1 = r1;
    bus.in0_valid  = drvV0;
    bus.in0_data   = drvD0;
    bus.in1_valid  = drvV1;
    bus.in1_data   = drvD1;
    bus.out0_ready = drvR0;
    bus.out1_ready = drvR1;
    #1;
    if (modelValid) checkOutput();
    else predAdv = 1'b0;
    @(posedge clk);
    updateModel(rstV);
  endtask

  // Idle cycles with both consumers ready, letting the pipeline drain.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
  endtask

  // Scoreboard monitor: every output handshake must match the oldest accepted word.
  task automatic popAndCompare(input int port);
    word_t w;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL delivery_underflow: port %0d delivered %0h with nothing expected at %0t",
               port, bus.out0_data, $time);
    end else begin
      w = expQ.pop_front();
      if (w.t !== 1'(port) || w.d !== bus.out0_data) begin
        mismatched++;
        $display("[TB] FAIL delivery: got port %0d data %0h expected port %0d data %0h at %0t",
                 port, bus.out0_data, w.t, w.d, $time);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (modelValid) begin
        if (bus.out0_valid === 1'b1 && bus.out0_ready === 1'b1) popAndCompare(0);
        if (bus.out1_valid === 1'b1 && bus.out1_ready === 1'b1) popAndCompare(1);
      end
    end
  end

  initial begin
    bus.in0_valid = 1'b0; bus.in0_data = '0;
    bus.in1_valid = 1'b0; bus.in1_data = '0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    drvV0 = 1'b0; drvV1 = 1'b0; drvR0 = 1'b1; drvR1 = 1'b1;
    drvD0 = '0; drvD1 = '0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);

    $display("[TB] single word from port 0");
    applyStimulus(1'b0, 1'b1, 5, 1'b0, 0, 1'b1, 1'b1);
    idle(6);

    $display("[TB] contention, alternating grants");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, i + 1, 1'b1, (i + 5) % 8, 1'b1, 1'b1);
    idle(12);

    $display("[TB] head stall on consumer 0");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, i + 2, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 7, 1'b0, 0, 1'b0, 1'b1);
    idle(8);

    $display("[TB] tag-1 head stalls, consumer 0 ready ignored");
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    idle(6);

    $display("[TB] reset with words in flight");
    applyStimulus(1'b0, 1'b1, 6, 1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 2, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1, 1'b1, 4, 1'b1, 1'b1);
    idle(8);

    $display("[TB] bubbles between single words");
    applyStimulus(1'b0, 1'b1, 3, 1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 6, 1'b1, 1'b1);
    idle(8);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 75));
    end
    idle(12);

    checkVal("drain_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
